// File: rtl/onchip_sample_memory.sv
// Single-port sample RAM with a slave port and a prefetching stream reader.
// Defining ONCHIP_SAMPLE_MEMORY_LOOP_EN makes the stream wrap to its base until stopped.
module onchip_sample_memory #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned DEPTH        = 240255,
    parameter int unsigned READ_LATENCY = 1,
    parameter              INIT_FILE    = "mem.mif"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic                    debugaccess,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    stream_start,
    input  logic [ADDR_WIDTH-1:0]   stream_base,
    input  logic [ADDR_WIDTH-1:0]   stream_length,
    input  logic                    stream_stop,
    output logic [DATA_WIDTH-1:0]   stream_data,
    output logic                    stream_valid,
    input  logic                    stream_ready,
    output logic                    stream_busy,
    output logic                    stream_done
);
    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    // The preload image is applied by the device configuration flow; only its name is carried.
    logic unused_init_file;
    assign unused_init_file = ^INIT_FILE;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
    logic                    done_q, done_d;
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
`endif

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_dout_q;
    logic                    s1_slave_q, s1_stream_q, s1_oor_q;

    logic [DATA_WIDTH-1:0]   fifo_q [4];
    logic [1:0]              wr_ptr_q, rd_ptr_q;
    logic [2:0]              count_q;

    logic                    en, slave_claim, wr_acc, rd_acc, active, flush, room, issue;
    logic                    ram_oor, ram_we, ram_re, push, pop;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [IdxWidth-1:0]     ram_idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        en          = ~waitrequest;
        slave_claim = en & chipselect & (read | write);
        wr_acc      = slave_claim & write & debugaccess;
        rd_acc      = slave_claim & read & ~write;
        active      = (state_q != StIdle);
        flush       = en & active & stream_stop;
        // In-flight reads count against FIFO space so a return can never overflow it.
        room        = (count_q + {2'b00, s1_stream_q}) < 3'd4;
        issue       = en & (state_q == StRun) & ~stream_stop & ~slave_claim & room;
        ram_addr    = slave_claim ? address : cur_addr_q;
        ram_idx     = ram_addr[IdxWidth-1:0];
        ram_oor     = 32'(ram_addr) >= DEPTH;
        ram_we      = wr_acc & ~ram_oor;
        ram_re      = rd_acc | issue;
        rd_word     = s1_oor_q ? '0 : ram_dout_q;
        push        = en & s1_stream_q & ~flush;
        pop         = en & (count_q != 3'd0) & stream_ready & ~flush;
    end

    assign waitrequest  = ~clken | reset_req;
    assign stream_valid = (count_q != 3'd0);
    assign stream_data  = stream_valid ? fifo_q[rd_ptr_q] : '0;
    assign stream_busy  = active;
    assign stream_done  = done_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < NumLanes; b++) begin
                if (byteenable[b]) mem_q[ram_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
        if (ram_re) ram_dout_q <= mem_q[ram_idx];
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        done_d     = done_q;
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
        base_d     = base_q;
        len_d      = len_q;
`endif
        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (stream_start) begin
                        if (stream_length != '0) begin
                            state_d    = StRun;
                            cur_addr_d = stream_base;
                            remain_d   = stream_length;
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
                            base_d     = stream_base;
                            len_d      = stream_length;
`endif
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (stream_stop) begin
                        state_d = StIdle;
                    end else if (issue) begin
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                        remain_d   = remain_q - ADDR_WIDTH'(1);
                        if (remain_q == ADDR_WIDTH'(1)) begin
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
                            cur_addr_d = base_q;
                            remain_d   = len_q;
`else
                            state_d    = StDrain;
`endif
                        end
                    end
                end
                StDrain: begin
                    if (stream_stop) begin
                        state_d = StIdle;
                    end else if ((count_q == 3'd0) && !s1_stream_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            done_q      <= 1'b0;
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
            base_q      <= '0;
            len_q       <= '0;
`endif
            s1_slave_q  <= 1'b0;
            s1_stream_q <= 1'b0;
            s1_oor_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            done_q     <= done_d;
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
            base_q     <= base_d;
            len_q      <= len_d;
`endif
            if (en) begin
                s1_slave_q  <= rd_acc;
                s1_stream_q <= issue;
                s1_oor_q    <= ram_oor;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
                count_q <= count_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= rd_word;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (en) begin
                rvalid_q <= s1_slave_q;
                if (s1_slave_q) rdata_q <= rd_word;
            end
        end
        assign readdata      = rdata_q;
        assign readdatavalid = rvalid_q;
    end else begin : g_lat1
        // RAM output is shared with the stream path, so a hold register keeps the last slave word.
        logic [DATA_WIDTH-1:0] hold_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else if (en && s1_slave_q) begin
                hold_q <= rd_word;
            end
        end
        assign readdata      = s1_slave_q ? rd_word : hold_q;
        assign readdatavalid = s1_slave_q;
    end

endmodule

// File: tb/tb_onchip_sample_memory.sv
// Randomised self-checking bench for onchip_sample_memory against an array-based model.
module tb_onchip_sample_memory;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 240255;
    localparam int unsigned RL    = 1;
    localparam int          ASPAN = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, reset_req, clken;
    logic [AW-1:0] address;
    logic [1:0]    byteenable;
    logic          chipselect, read, write, debugaccess;
    logic [DW-1:0] writedata, readdata;
    logic          readdatavalid, waitrequest;
    logic          stream_start, stream_stop, stream_ready;
    logic [AW-1:0] stream_base, stream_length;
    logic [DW-1:0] stream_data;
    logic          stream_valid, stream_busy, stream_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit [DW-1:0] ref_mem [ASPAN];

    typedef struct {int due; logic [DW-1:0] data;} rd_exp_t;

    onchip_sample_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL), .INIT_FILE("mem.mif")
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .address(address), .byteenable(byteenable), .chipselect(chipselect), .read(read),
        .write(write), .debugaccess(debugaccess), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .stream_start(stream_start), .stream_base(stream_base), .stream_length(stream_length),
        .stream_stop(stream_stop), .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .stream_busy(stream_busy), .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [DW-1:0] ref_read(input int a);
        return (a >= int'(DEPTH)) ? '0 : ref_mem[a % ASPAN];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        chipselect = 0; read = 0; write = 0; debugaccess = 0; byteenable = 2'b11;
        address = '0; writedata = '0; stream_start = 0; stream_stop = 0;
        stream_base = '0; stream_length = '0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [1:0] be,
                            input logic dbg);
        chipselect = 1; write = 1; read = 0; address = AW'(a); writedata = d;
        byteenable = be; debugaccess = dbg;
        step();
        chipselect = 0; write = 0; debugaccess = 0;
        if (dbg && a < int'(DEPTH)) begin
            if (be[0]) ref_mem[a][7:0]  = d[7:0];
            if (be[1]) ref_mem[a][15:8] = d[15:8];
        end
    endtask

    task automatic do_read(input int a, output logic [DW-1:0] d, output int lat);
        chipselect = 1; read = 1; write = 0; address = AW'(a);
        step();
        chipselect = 0; read = 0;
        lat = 1;
        while (!readdatavalid && lat < 6) begin
            step();
            lat++;
        end
        d = readdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        clken = 1; reset_req = 0; stream_ready = 0; reset = 1;
        step(); step();
        reset = 0;
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %0h want 0", readdatavalid); end
        checks++; if (readdata !== '0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
        checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL reset_svalid got %0h want 0", stream_valid); end
        checks++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", stream_busy); end
        checks++; if (stream_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", stream_done); end
        checks++; if (stream_data !== '0) begin errors++; $display("FAIL reset_sdata got %h want 0", stream_data); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got %0h want 0", waitrequest); end
    endtask

    task automatic test_waitrequest();
        logic [DW-1:0] d;
        int lat;
        do_write(300, 16'h1111, 2'b11, 1'b1);
        clken = 0; #1;
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL wait_clken got %0h want 1", waitrequest); end
        clken = 1; reset_req = 1; #1;
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL wait_rreq got %0h want 1", waitrequest); end
        chipselect = 1; write = 1; debugaccess = 1; address = AW'(300); writedata = 16'h2222;
        step();
        write = 0; debugaccess = 0; read = 1;
        step();
        chipselect = 0; read = 0;
        for (int k = 0; k < int'(RL) + 1; k++) begin
            checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL wait_rd_blocked got %0h want 0", readdatavalid); end
            step();
        end
        reset_req = 0; #1;
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL wait_release got %0h want 0", waitrequest); end
        do_read(300, d, lat);
        checks++; if (d !== 16'h1111) begin errors++; $display("FAIL wait_wr_blocked got %h want 1111", d); end
    endtask

    task automatic test_byte_write();
        logic [DW-1:0] d;
        int lat;
        do_write(5, 16'h1234, 2'b11, 1'b1);
        do_write(5, 16'hBEEF, 2'b10, 1'b1);
        do_read(5, d, lat);
        checks++; if (d !== 16'hBE34) begin errors++; $display("FAIL byte_write got %h want be34", d); end
        checks++; if (lat != int'(RL)) begin errors++; $display("FAIL byte_write_lat got %0d want %0d", lat, RL); end
    endtask

    task automatic test_no_debug();
        logic [DW-1:0] d;
        int lat;
        do_write(7, 16'h5A5A, 2'b11, 1'b1);
        do_write(7, 16'hAAAA, 2'b11, 1'b0);
        do_read(7, d, lat);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL no_debug got %h want 5a5a", d); end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        int lat;
        do_write(int'(DEPTH), 16'hFFFF, 2'b11, 1'b1);
        do_read(int'(DEPTH), d, lat);
        checks++; if (d !== '0) begin errors++; $display("FAIL oor_depth got %h want 0", d); end
        checks++; if (lat != int'(RL)) begin errors++; $display("FAIL oor_lat got %0d want %0d", lat, RL); end
        do_read(ASPAN - 1, d, lat);
        checks++; if (d !== '0) begin errors++; $display("FAIL oor_top got %h want 0", d); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d;
        int lat;
        do_write(20, 16'h0F0F, 2'b11, 1'b1);
        chipselect = 1; read = 1; write = 1; debugaccess = 1; address = AW'(20);
        writedata = 16'h7777; byteenable = 2'b11;
        step();
        chipselect = 0; read = 0; write = 0; debugaccess = 0;
        ref_mem[20] = 16'h7777;
        for (int k = 0; k < int'(RL) + 1; k++) begin
            checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL collide_rdv got %0h want 0", readdatavalid); end
            step();
        end
        do_read(20, d, lat);
        checks++; if (d !== 16'h7777) begin errors++; $display("FAIL collide_write got %h want 7777", d); end
    endtask

    task automatic test_random_slave();
        logic [DW-1:0] d;
        int lat, a;
        for (int i = 200; i < 216; i++) do_write(i, 16'($urandom), 2'b11, 1'b1);
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 7) == 0) ? int'(DEPTH) + $urandom_range(0, 99)
                                            : 200 + $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 16'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
            end else begin
                do_read(a, d, lat);
                checks++; if (d !== ref_read(a) || lat != int'(RL)) begin errors++; $display("FAIL rand_read addr %0d got %h lat %0d want %h lat %0d", a, d, lat, ref_read(a), RL); end
            end
        end
    endtask

    task automatic test_stream_basic();
        logic [DW-1:0] got[$];
        rd_exp_t pend[$];
        rd_exp_t e;
        int done_cnt = 0;
        int a;
        for (int i = 100; i < 108; i++) do_write(i, 16'($urandom), 2'b11, 1'b1);
        stream_start = 1; stream_base = AW'(100); stream_length = AW'(8);
        step();
        stream_start = 0;
        for (int k = 0; k < 80; k++) begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                checks++; if (readdatavalid !== 1'b1 || readdata !== e.data) begin errors++; $display("FAIL sb_slave_read got v%0h %h want v1 %h", readdatavalid, readdata, e.data); end
            end else begin
                checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL sb_slave_idle got %0h want 0", readdatavalid); end
            end
            if (stream_done) begin
                done_cnt++;
                checks++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_at_done got %0h want 0", stream_busy); end
            end
            stream_ready = cyc[0];
            if (stream_valid && stream_ready) got.push_back(stream_data);
            if (cyc % 3 == 0) begin
                a = 100 + $urandom_range(0, 7);
                chipselect = 1; read = 1; address = AW'(a);
                e.due = cyc + int'(RL); e.data = ref_read(a);
                pend.push_back(e);
            end else begin
                chipselect = 0; read = 0;
            end
            // A second start while busy must be ignored.
            stream_start = (k == 5); stream_base = AW'(500); stream_length = AW'(2);
            step();
        end
        idle_inputs(); stream_ready = 0;
        checks++; if (got.size() != 8) begin errors++; $display("FAIL sb_count got %0d want 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] !== ref_read(100 + i)) begin errors++; $display("FAIL sb_word%0d got %h want %h", i, got[i], ref_read(100 + i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sb_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_stream_wrap();
        logic [DW-1:0] got[$];
        int base = ASPAN - 2;
        do_write(0, 16'($urandom), 2'b11, 1'b1);
        do_write(1, 16'($urandom), 2'b11, 1'b1);
        stream_start = 1; stream_base = AW'(base); stream_length = AW'(4);
        step();
        stream_start = 0; stream_ready = 1;
        for (int k = 0; k < 40 && !stream_done; k++) begin
            if (stream_valid) got.push_back(stream_data);
            step();
        end
        stream_ready = 0;
        checks++; if (stream_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0h want 1", stream_done); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== ref_read((base + i) % ASPAN)) begin errors++; $display("FAIL wrap_word%0d got %h want %h", i, got[i], ref_read((base + i) % ASPAN)); end
        end
        step();
    endtask

    task automatic test_stream_zero();
        stream_start = 1; stream_base = AW'(10); stream_length = '0;
        step();
        stream_start = 0;
        checks++; if (stream_done !== 1'b1 || stream_busy !== 1'b0) begin errors++; $display("FAIL zero_len got done %0h busy %0h want 1 0", stream_done, stream_busy); end
        step();
        checks++; if (stream_done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse got %0h want 0", stream_done); end
    endtask

    task automatic test_stream_stop();
        logic [DW-1:0] got[$];
        int done_cnt = 0;
        for (int i = 40; i < 48; i++) do_write(i, 16'($urandom), 2'b11, 1'b1);
        stream_start = 1; stream_base = AW'(40); stream_length = AW'(8);
        step();
        stream_start = 0; stream_ready = 1;
        for (int k = 0; k < 40 && got.size() < 3; k++) begin
            if (stream_valid) got.push_back(stream_data);
            if (stream_done) done_cnt++;
            step();
        end
        stream_ready = 0; stream_stop = 1;
        step();
        stream_stop = 0;
        checks++; if (stream_valid !== 1'b0 || stream_busy !== 1'b0) begin errors++; $display("FAIL stop_state got valid %0h busy %0h want 0 0", stream_valid, stream_busy); end
        for (int k = 0; k < 10; k++) begin
            if (stream_done) done_cnt++;
            step();
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL stop_no_done got %0d want 0", done_cnt); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL stop_count got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] !== ref_read(40 + i)) begin errors++; $display("FAIL stop_word%0d got %h want %h", i, got[i], ref_read(40 + i)); end
        end
    endtask

    task automatic test_stream_reset();
        logic [DW-1:0] d;
        int lat;
        int done_cnt = 0;
        stream_start = 1; stream_base = AW'(40); stream_length = AW'(8);
        step();
        stream_start = 0; stream_ready = 0;
        step(); step();
        checks++; if (stream_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %0h want 1", stream_busy); end
        reset = 1;
        step();
        reset = 0;
        checks++; if (stream_valid !== 1'b0 || stream_busy !== 1'b0 || stream_done !== 1'b0) begin errors++; $display("FAIL rst_mid got v%0h b%0h d%0h want 0 0 0", stream_valid, stream_busy, stream_done); end
        for (int k = 0; k < 10; k++) begin
            if (stream_done) done_cnt++;
            step();
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_cnt); end
        do_read(41, d, lat);
        checks++; if (d !== ref_read(41)) begin errors++; $display("FAIL rst_ram_kept got %h want %h", d, ref_read(41)); end
    endtask

`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
    task automatic test_loop();
        logic [DW-1:0] got[$];
        int done_cnt = 0;
        for (int i = 0; i < 3; i++) do_write(i, 16'($urandom), 2'b11, 1'b1);
        stream_start = 1; stream_base = '0; stream_length = AW'(3);
        step();
        stream_start = 0; stream_ready = 1;
        for (int k = 0; k < 60 && got.size() < 10; k++) begin
            if (stream_valid) got.push_back(stream_data);
            if (stream_done) done_cnt++;
            step();
        end
        stream_ready = 0; stream_stop = 1;
        step();
        stream_stop = 0;
        checks++; if (stream_busy !== 1'b0) begin errors++; $display("FAIL loop_stop got %0h want 0", stream_busy); end
        checks++; if (got.size() != 10) begin errors++; $display("FAIL loop_count got %0d want 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== ref_read(i % 3)) begin errors++; $display("FAIL loop_word%0d got %h want %h", i, got[i], ref_read(i % 3)); end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL loop_no_done got %0d want 0", done_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_waitrequest();
        test_byte_write();
        test_no_debug();
        test_out_of_range();
        test_collision();
        test_random_slave();
`ifdef ONCHIP_SAMPLE_MEMORY_LOOP_EN
        test_loop();
`else
        test_stream_basic();
        test_stream_wrap();
`endif
        test_stream_zero();
        test_stream_stop();
        test_stream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onchip_sample_memory.md
ONCHIP_SAMPLE_MEMORY -- requirements
Module: onchip_sample_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, word address width.
REQ-003 SHALL have parameter DEPTH, default 240255, implemented words, at most 2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted read to data.
REQ-005 SHALL have parameter INIT_FILE, default "mem.mif", memory initialisation image.
REQ-006 Ports, in order (name, direction, width, meaning): clk in 1 clock; reset in 1 reset; reset_req in 1 access inhibit; clken in 1 clock enable.
REQ-007 Further ports: address in ADDR_WIDTH word address; byteenable in DATA_WIDTH/8 lane enables; chipselect in 1 slave select; read in 1 read strobe; write in 1 write strobe; debugaccess in 1 write permit.
REQ-008 Further ports: writedata in DATA_WIDTH; readdata out DATA_WIDTH; readdatavalid out 1; waitrequest out 1.
REQ-009 Stream ports: stream_start in 1; stream_base in ADDR_WIDTH; stream_length in ADDR_WIDTH, word count; stream_stop in 1; stream_data out DATA_WIDTH; stream_valid out 1; stream_ready in 1; stream_busy out 1; stream_done out 1, one-cycle pulse.
REQ-010 One clock, clk; reset is synchronous and active-high, named reset.

Function
REQ-011 Storage: single-port synchronous RAM, DEPTH words, preloaded from INIT_FILE; at most one access per cycle.
REQ-012 waitrequest = ~clken | reset_req; no slave or stream access is accepted while it is high, and all state holds.
REQ-013 Write accepted when chipselect & write & debugaccess & ~waitrequest; only lanes with byteenable high update; write without debugaccess is silently dropped.
REQ-014 Read accepted when chipselect & read & ~waitrequest; readdata valid with readdatavalid high exactly READ_LATENCY cycles later; readdata holds last value otherwise.
REQ-015 Address >= DEPTH: write ignored, read returns zero with normal readdatavalid timing.
REQ-016 Simultaneous read and write strobes: write wins, no readdatavalid.
REQ-017 Stream FSM states IDLE, RUN, DRAIN; IDLE->RUN on stream_start with stream_length != 0, capturing base and length; stream_length == 0 pulses stream_done next cycle, stays IDLE.
REQ-018 RUN issues one RAM read per cycle from base upward when the RAM is not claimed by the slave port and FIFO occupancy plus in-flight reads < 4; slave access always has priority.
REQ-019 Returned words enter a 4-entry FIFO; stream_valid = FIFO non-empty; a word pops when stream_valid & stream_ready; order strictly ascending address.
REQ-020 RUN->DRAIN after final address issued; DRAIN->IDLE when FIFO empty and no reads in flight, pulsing stream_done for one cycle.
REQ-021 stream_start ignored while stream_busy; stream_busy high in RUN and DRAIN.
REQ-022 stream_stop in RUN or DRAIN: stops issuing, flushes FIFO, discards in-flight returns, IDLE next cycle, no stream_done.
REQ-023 Stream address computed modulo 2^ADDR_WIDTH; out-of-range addresses yield zero words per REQ-015.

Reset
REQ-024 On reset: FSM IDLE, FIFO empty, in-flight cleared, readdatavalid 0, stream_valid 0, stream_busy 0, stream_done 0, readdata 0, stream_data 0.
REQ-025 Reset mid-stream abandons the transfer without stream_done; RAM contents are not altered by reset.

Configuration
REQ-026 Macro ONCHIP_SAMPLE_MEMORY_LOOP_EN defined: after final word of a run, issue address returns to captured base and RUN continues until stream_stop; DRAIN and stream_done never occur.
REQ-027 Macro undefined: single-pass behaviour per REQ-020.

Verification
REQ-028 Write 0xBEEF to address 5 with byteenable 2'b10, debugaccess 1, over initial 0x1234; read 5 -> 0xBE34 after READ_LATENCY cycles.
REQ-029 Write 0xAAAA to address 7 with debugaccess 0; read 7 -> original INIT_FILE value unchanged.
REQ-030 Read address DEPTH (240255) -> readdata 0, readdatavalid after READ_LATENCY cycles.
REQ-031 stream_start base 100, length 8, stream_ready toggling every cycle, slave read every third cycle -> words 100..107 in order, none lost, one stream_done pulse.
REQ-032 Stream length 8, stream_stop after 3 words popped -> stream_valid 0 and stream_busy 0 next cycle, no stream_done; reset during RUN -> same.
REQ-033 With ONCHIP_SAMPLE_MEMORY_LOOP_EN, base 0, length 3 -> stream sequence 0,1,2,0,1,2,... until stream_stop.
